// File: rtl/aes_pkg.sv
// Shared AES constants for the decryption datapath.
// Holds the byte type, the FIPS-197 inverse S-box used by the InvSubBytes
// lookup, and the forward S-box kept alongside it for cross-checking.
package aes_pkg;

    typedef logic [7:0] aes_byte_t;

    // Inverse S-box, row-major: entry [16*hi + lo] for address {hi, lo}.
    localparam aes_byte_t INV_SBOX [256] = '{
        // 0x00
        8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38,
        8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
        // 0x10
        8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87,
        8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
        // 0x20
        8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d,
        8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
        // 0x30
        8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2,
        8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
        // 0x40
        8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16,
        8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
        // 0x50
        8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda,
        8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
        // 0x60
        8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a,
        8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
        // 0x70
        8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02,
        8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
        // 0x80
        8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea,
        8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
        // 0x90
        8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85,
        8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
        // 0xa0
        8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89,
        8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
        // 0xb0
        8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20,
        8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
        // 0xc0
        8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31,
        8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
        // 0xd0
        8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d,
        8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
        // 0xe0
        8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0,
        8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
        // 0xf0
        8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26,
        8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
    };

    // Forward S-box; not used by the lookup itself, kept for cross-checks.
    localparam aes_byte_t SBOX [256] = '{
        // 0x00
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5,
        8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        // 0x10
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0,
        8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        // 0x20
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc,
        8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        // 0x30
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a,
        8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        // 0x40
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0,
        8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        // 0x50
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b,
        8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        // 0x60
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85,
        8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        // 0x70
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5,
        8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        // 0x80
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17,
        8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        // 0x90
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88,
        8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        // 0xa0
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c,
        8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        // 0xb0
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9,
        8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        // 0xc0
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6,
        8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        // 0xd0
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e,
        8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        // 0xe0
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94,
        8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        // 0xf0
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68,
        8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

endpackage

// File: rtl/inv_sbox_lut.sv
// Combinational InvSubBytes lookup: one byte in, its inverse S-box image out.
// Every 8-bit address is a valid table index, so there is no default path.
module inv_sbox_lut
    import aes_pkg::*;
(
    input  logic [7:0] rom_addr,
    output logic [7:0] data_o
);

    // Pure table read; synthesis folds the constant array into logic or ROM.
    always_comb begin
        data_o = INV_SBOX[rom_addr];
    end

endmodule

// File: rtl/inv_sbox_rom.sv
// AES inverse S-box ROM for one byte lane of the InvSubBytes stage.
// Optional build macro: INV_SBOX_COMB_OUT_EN
//   undefined (default): data_o is registered, 1-cycle latency, resets to 8'h00.
//   defined:             data_o follows rom_addr combinationally, no reset value.
// Interface timing: there is no valid/ready handshake. A new address is taken
// every cycle and the caller accounts for the fixed latency of the build.
module inv_sbox_rom
    import aes_pkg::*;
(
    input  logic       clk_i,
    input  logic       reset_n_i,
    input  logic [7:0] rom_addr,
    output logic [7:0] data_o
);

    logic [7:0] lut_data;

    inv_sbox_lut u_lut (
        .rom_addr (rom_addr),
        .data_o   (lut_data)
    );

`ifdef INV_SBOX_COMB_OUT_EN

    // Clock and reset stay on the port list for drop-in compatibility only.
    logic unused_clk_rst;
    assign unused_clk_rst = clk_i ^ reset_n_i;

    // Zero-latency path straight from the lookup.
    always_comb begin
        data_o = lut_data;
    end

`else

    // Output register: async clear drops any pending lookup immediately.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            data_o <= 8'h00;
        end else begin
            data_o <= lut_data;
        end
    end

`endif

endmodule

// File: tb/tb_inv_sbox_rom.sv
// Self-checking bench for inv_sbox_rom.
// Expected values come from hard-coded anchors and from a reference table the
// bench builds itself by inverting the forward S-box.
module tb_inv_sbox_rom;
    import aes_pkg::*;

    logic       clk;
    logic       reset_n;
    logic [7:0] rom_addr;
    logic [7:0] data_o;

    int unsigned n_cmp  = 0;
    int unsigned n_fail = 0;

    logic [7:0] exp_q[$];
    string      tag_q[$];
    logic [7:0] model_inv [256];

    inv_sbox_rom dut (
        .clk_i     (clk),
        .reset_n_i (reset_n),
        .rom_addr  (rom_addr),
        .data_o    (data_o)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Pop the oldest expectation and compare it with the current output.
    task automatic retire();
        logic [7:0] e;
        string      t;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            t = tag_q.pop_front();
            check(t, data_o, e);
        end
    endtask

    // One cycle: retire last cycle's lookup, then present a new address.
    task automatic step(input logic [7:0] a, input logic [7:0] e, input string tag);
        @(negedge clk);
        retire();
        rom_addr = a;
        exp_q.push_back(e);
        tag_q.push_back(tag);
    endtask

    task automatic flush();
        @(negedge clk);
        retire();
    endtask

    initial begin
        logic [7:0] a;

        // Reference table built only from the forward S-box.
        for (int x = 0; x < 256; x++) begin
            model_inv[SBOX[x]] = 8'(x);
        end

        reset_n  = 1'b0;
        rom_addr = 8'h00;

`ifdef INV_SBOX_COMB_OUT_EN
        #1;
        rom_addr = 8'h02;
        #1 check("comb_02", data_o, 8'h6a);
        rom_addr = 8'h03;
        #1 check("comb_03", data_o, 8'hd5);
        for (int x = 0; x < 256; x++) begin
            rom_addr = 8'(x);
            #1 check($sformatf("comb_sweep_%02h", x), data_o, model_inv[x]);
        end
        for (int x = 0; x < 256; x++) begin
            rom_addr = SBOX[x];
            #1 check($sformatf("comb_inv_%02h", x), data_o, 8'(x));
        end
`else
        // Reset value before any clock edge.
        #3 check("rst_before_edge", data_o, 8'h00);
        // An edge under reset must not load the table.
        @(negedge clk);
        check("rst_held_over_edge", data_o, 8'h00);
        reset_n = 1'b1;
        exp_q.push_back(8'h52);
        tag_q.push_back("first_after_release");

        // Anchors.
        step(8'h01, 8'h09, "anchor_01");
        step(8'h63, 8'h00, "anchor_63");
        step(8'hff, 8'h7d, "anchor_ff");
        step(8'h52, 8'h48, "anchor_52");
        step(8'h7c, 8'h01, "anchor_7c");
        step(8'hed, 8'h53, "anchor_ed");
        step(8'h02, 8'h6a, "anchor_02");
        step(8'h03, 8'hd5, "anchor_03");

        // Back-to-back with no bubbles.
        step(8'h0f, 8'hfb, "b2b_0f");
        step(8'h10, 8'h7c, "b2b_10");
        step(8'h16, 8'hff, "b2b_16");

        // Exhaustive sweep.
        for (int x = 0; x < 256; x++) begin
            step(8'(x), model_inv[x], $sformatf("sweep_%02h", x));
        end

        // Inverse property: lookup of SBOX[x] returns x.
        for (int x = 0; x < 256; x++) begin
            step(SBOX[x], 8'(x), $sformatf("inverse_%02h", x));
        end

        // Random addresses.
        for (int i = 0; i < 32; i++) begin
            a = 8'($urandom_range(0, 255));
            step(a, model_inv[a], $sformatf("rand_%02h", a));
        end

        // Mid-stream asynchronous reset while data_o holds 7d.
        step(8'hff, 8'h7d, "pre_reset_ff");
        step(8'h16, 8'hff, "discarded_16");
        exp_q.delete();
        tag_q.delete();
        #2 reset_n = 1'b0;
        #1 check("async_reset_clear", data_o, 8'h00);
        @(negedge clk);
        check("reset_hold_mid", data_o, 8'h00);
        rom_addr = 8'h03;
        reset_n  = 1'b1;
        exp_q.push_back(8'hd5);
        tag_q.push_back("post_reset_03");
        flush();
        flush();
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
